// File: rtl/mem_store_data_forward.sv
// MEM-stage store-data forwarding against the WB result and a DEPTH-entry retired-write history.
// Optional FWD_PERF_EN adds Fwd_Count, a saturating count of forwarded-store cycles.

module fwd_tag_cmp #(
  parameter int REG_W = 5
) (
  input  logic             vld,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rt,
  input  logic             store,
  output logic             hit
);
  // $zero never forwards, even if a stale tag slipped through.
  assign hit = store & vld & (rd == rt) & (rt != '0);
endmodule

module mem_store_data_forward #(
  parameter  int DATA_W = 32,
  parameter  int REG_W  = 5,
  parameter  int DEPTH  = 2,
  localparam int SRC_W  = $clog2(DEPTH+1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WB_Valid,
  input  logic              WB_RegWrite,
  input  logic [REG_W-1:0]  WB_Rd,
  input  logic [DATA_W-1:0] WB_Data,
  input  logic              MEM_Store,
  input  logic [REG_W-1:0]  MEM_Rt,
  input  logic [DATA_W-1:0] Write_Data_MEM,
  output logic [DATA_W-1:0] Write_Data_MUX_MEM,
  output logic              Fwd_Hit,
  output logic [SRC_W-1:0]  Fwd_Src
`ifdef FWD_PERF_EN
  ,
  output logic [31:0]       Fwd_Count
`endif
);

  // Candidate slot 0 is the live WB write; slots 1..DEPTH are retired history, youngest first.
  logic [DEPTH:1]             vld_pipe;
  logic [DEPTH:1][REG_W-1:0]  rd_pipe;
  logic [DEPTH:1][DATA_W-1:0] data_pipe;

  logic [DEPTH:0]             cand_vld;
  logic [DEPTH:0][REG_W-1:0]  cand_rd;
  logic [DEPTH:0][DATA_W-1:0] cand_data;
  logic [DEPTH:0]             hit_vec;

  assign cand_vld  = {vld_pipe, WB_Valid & WB_RegWrite & (WB_Rd != '0)};
  assign cand_rd   = {rd_pipe, WB_Rd};
  assign cand_data = {data_pipe, WB_Data};

  // History advances only on real retirements; bubbles leave it untouched.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)         vld_pipe <= '0;
    else if (WB_Valid) vld_pipe <= cand_vld[DEPTH-1:0];
  end

  always_ff @(posedge Clk) begin
    if (WB_Valid) begin
      rd_pipe   <= cand_rd[DEPTH-1:0];
      data_pipe <= cand_data[DEPTH-1:0];
    end
  end

  for (genvar k = 0; k <= DEPTH; k++) begin : g_cmp
    fwd_tag_cmp #(.REG_W(REG_W)) u_cmp (
      .vld  (cand_vld[k]),
      .rd   (cand_rd[k]),
      .rt   (MEM_Rt),
      .store(MEM_Store),
      .hit  (hit_vec[k])
    );
  end

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    Write_Data_MUX_MEM = Write_Data_MEM;
    Fwd_Hit            = 1'b0;
    Fwd_Src            = '0;
    if (!Reset) begin
      for (int k = DEPTH; k >= 0; k--) begin
        if (hit_vec[k]) begin
          Write_Data_MUX_MEM = cand_data[k];
          Fwd_Hit            = 1'b1;
          Fwd_Src            = SRC_W'(k);
        end
      end
    end
  end

`ifdef FWD_PERF_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                            Fwd_Count <= '0;
    else if (Fwd_Hit && Fwd_Count != '1)  Fwd_Count <= Fwd_Count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_store_data_forward.sv
// Table-driven bench for mem_store_data_forward (DEPTH=2) with an expectation queue,
// plus a hand sequence for a reset pulse landing between clock edges.
module tb_mem_store_data_forward;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int DEPTH  = 2;
  localparam int SRC_W  = 2;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              WB_Valid = 1'b0, WB_RegWrite = 1'b0;
  logic [REG_W-1:0]  WB_Rd = '0;
  logic [DATA_W-1:0] WB_Data = '0;
  logic              MEM_Store = 1'b0;
  logic [REG_W-1:0]  MEM_Rt = '0;
  logic [DATA_W-1:0] Write_Data_MEM = '0;
  logic [DATA_W-1:0] Write_Data_MUX_MEM;
  logic              Fwd_Hit;
  logic [SRC_W-1:0]  Fwd_Src;
`ifdef FWD_PERF_EN
  logic [31:0]       Fwd_Count;
`endif

  mem_store_data_forward #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .WB_Valid(WB_Valid), .WB_RegWrite(WB_RegWrite),
    .WB_Rd(WB_Rd), .WB_Data(WB_Data), .MEM_Store(MEM_Store), .MEM_Rt(MEM_Rt),
    .Write_Data_MEM(Write_Data_MEM), .Write_Data_MUX_MEM(Write_Data_MUX_MEM),
    .Fwd_Hit(Fwd_Hit), .Fwd_Src(Fwd_Src)
`ifdef FWD_PERF_EN
    , .Fwd_Count(Fwd_Count)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic rst, wv, wrw; logic [4:0] wrd; logic [31:0] wdat;
    logic st; logic [4:0] rt; logic [31:0] wdm;
    logic [31:0] eout; logic ehit; logic [1:0] esrc;
  } vec_t;

  typedef struct { logic [31:0] out; logic hit; logic [1:0] src; } exp_t;

  exp_t        sb[$];
  int          n_vec = 0, n_miss = 0;
  logic        cur_ehit = 1'b0;
  logic [31:0] exp_cnt;
  vec_t        tbl[29];

  always @(posedge Clk or posedge Reset) begin
    if (Reset) exp_cnt <= '0;
    else if (cur_ehit && exp_cnt != 32'hFFFF_FFFF) exp_cnt <= exp_cnt + 32'd1;
  end

  function automatic vec_t mk(logic rst, logic wv, logic wrw, logic [4:0] wrd, logic [31:0] wdat,
                              logic st, logic [4:0] rt, logic [31:0] wdm,
                              logic [31:0] eout, logic ehit, logic [1:0] esrc);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wrw = wrw; v.wrd = wrd; v.wdat = wdat;
    v.st = st; v.rt = rt; v.wdm = wdm; v.eout = eout; v.ehit = ehit; v.esrc = esrc;
    return v;
  endfunction

  task automatic push_exp(input logic [31:0] out, input logic hit, input logic [1:0] src);
    exp_t e;
    e.out = out; e.hit = hit; e.src = src;
    sb.push_back(e);
    cur_ehit = hit;
  endtask

  task automatic drive(input vec_t v);
    Reset = v.rst; WB_Valid = v.wv; WB_RegWrite = v.wrw; WB_Rd = v.wrd; WB_Data = v.wdat;
    MEM_Store = v.st; MEM_Rt = v.rt; Write_Data_MEM = v.wdm;
    push_exp(v.eout, v.ehit & ~v.rst, v.esrc);
  endtask

  task automatic check(input string tag);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL %s: scoreboard empty, out=%h hit=%b src=%0d", tag, Write_Data_MUX_MEM, Fwd_Hit, Fwd_Src);
      return;
    end
    e = sb.pop_front();
    if (Write_Data_MUX_MEM !== e.out || Fwd_Hit !== e.hit || Fwd_Src !== e.src) begin
      n_miss++;
      $display("FAIL %s: got out=%h hit=%b src=%0d, want out=%h hit=%b src=%0d",
               tag, Write_Data_MUX_MEM, Fwd_Hit, Fwd_Src, e.out, e.hit, e.src);
    end
`ifdef FWD_PERF_EN
    n_vec++;
    if (Fwd_Count !== exp_cnt) begin
      n_miss++;
      $display("FAIL %s count: got %0d want %0d", tag, Fwd_Count, exp_cnt);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1,1,1, 5,32'hDEAD_0000, 1, 5,32'h1111_1111, 32'h1111_1111,0,0);
    tbl[1]  = mk(0,1,1, 5,32'h5555_5555, 0, 5,32'h1111_1111, 32'h1111_1111,0,0);
    tbl[2]  = mk(0,1,1, 6,32'h0000_0066, 0, 5,32'h1111_1111, 32'h1111_1111,0,0);
    tbl[3]  = mk(0,0,0, 0,32'h0,         1, 5,32'h2222_2222, 32'h5555_5555,1,2);
    tbl[4]  = mk(1,0,0, 0,32'h0,         1, 5,32'h2222_2222, 32'h2222_2222,0,0);
    tbl[5]  = mk(0,0,0, 0,32'h0,         1, 5,32'h1111_1111, 32'h1111_1111,0,0);
    tbl[6]  = mk(0,1,1, 5,32'hDEAD_BEEF, 1, 5,32'h1111_1111, 32'hDEAD_BEEF,1,0);
    tbl[7]  = mk(0,1,1, 7,32'hA5A5_A5A5, 0, 0,32'h0,         32'h0,        0,0);
    tbl[8]  = mk(0,0,1, 7,32'h0BAD_0BAD, 1, 7,32'h77,        32'hA5A5_A5A5,1,1);
    tbl[9]  = mk(0,0,1, 7,32'h0BAD_0BAD, 1, 7,32'h77,        32'hA5A5_A5A5,1,1);
    tbl[10] = mk(0,0,1, 7,32'h0BAD_0BAD, 1, 7,32'h77,        32'hA5A5_A5A5,1,1);
    tbl[11] = mk(0,1,1, 3,32'h3,         0, 3,32'h0,         32'h0,        0,0);
    tbl[12] = mk(0,1,1, 3,32'h1,         0, 3,32'h0,         32'h0,        0,0);
    tbl[13] = mk(0,1,1, 4,32'h4,         1, 3,32'hCC,        32'h1,        1,1);
    tbl[14] = mk(0,1,1, 3,32'h2,         1, 3,32'hCC,        32'h2,        1,0);
    tbl[15] = mk(0,1,0, 3,32'hEE,        1, 3,32'hCC,        32'h2,        1,1);
    tbl[16] = mk(0,0,0, 0,32'h0,         1, 3,32'hCC,        32'h2,        1,2);
    tbl[17] = mk(0,1,1, 0,32'hFFFF_FFFF, 1, 0,32'h0,         32'h0,        0,0);
    tbl[18] = mk(0,0,0, 0,32'h0,         1, 0,32'h0,         32'h0,        0,0);
    tbl[19] = mk(0,1,1, 9,32'h99,        0, 0,32'h0,         32'h0,        0,0);
    tbl[20] = mk(0,1,1,10,32'hA,         1, 9,32'h5,         32'h99,       1,1);
    tbl[21] = mk(0,1,1,11,32'hB,         1, 9,32'h5,         32'h99,       1,2);
    tbl[22] = mk(0,1,1,12,32'hC,         1, 9,32'h5,         32'h5,        0,0);
    tbl[23] = mk(0,0,0, 0,32'h0,         1, 9,32'h5,         32'h5,        0,0);
    tbl[24] = mk(0,1,1,12,32'hC2,        0,12,32'h5,         32'h5,        0,0);
    tbl[25] = mk(0,1,1,31,32'h8000_0001, 1,31,32'h1,         32'h8000_0001,1,0);
    tbl[26] = mk(0,0,0, 0,32'h0,         1,31,32'h1,         32'h8000_0001,1,1);
    tbl[27] = mk(1,0,0, 0,32'h0,         1,31,32'h1,         32'h1,        0,0);
    tbl[28] = mk(0,0,0, 0,32'h0,         1,31,32'h1,         32'h1,        0,0);

    push_exp(32'h0, 1'b0, 2'd0);
    @(negedge Clk);
    check("reset_state");

    for (int i = 0; i < 29; i++) begin
      @(posedge Clk); #1;
      drive(tbl[i]);
      @(negedge Clk);
      check($sformatf("vec%0d", i));
    end

    // Reset pulse between edges must clear history without a clock.
    @(posedge Clk); #1;
    Reset = 1'b0; WB_Valid = 1'b1; WB_RegWrite = 1'b1; WB_Rd = 5'd5; WB_Data = 32'h1234_5678;
    MEM_Store = 1'b0; MEM_Rt = 5'd5; Write_Data_MEM = 32'hAAAA_AAAA;
    push_exp(32'hAAAA_AAAA, 1'b0, 2'd0);
    @(negedge Clk);
    check("async_load");
    @(posedge Clk); #1;
    WB_Valid = 1'b0; MEM_Store = 1'b1;
    push_exp(32'h1234_5678, 1'b1, 2'd1);
    @(negedge Clk);
    check("async_hit");
    #2;
    Reset = 1'b1;
    push_exp(32'hAAAA_AAAA, 1'b0, 2'd0);
    #1;
    check("async_rst_on");
    Reset = 1'b0;
    push_exp(32'hAAAA_AAAA, 1'b0, 2'd0);
    #1;
    check("async_rst_off");
    push_exp(32'hAAAA_AAAA, 1'b0, 2'd0);
    @(posedge Clk); @(negedge Clk);
    check("async_after_edge");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
